// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } arb_state_t;

    localparam int DEF_N     = 2;
    localparam int DEF_W     = 8;
    localparam int DEF_BURST = 4;

    // Counter must hold 0..BURST-1 while never overflowing at the release compare.
    function automatic int cnt_width(input int burst);
        return $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting after the last-served index
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             valid
);

    int idx;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        valid    = 1'b0;
        idx      = 0;
        for (int i = 1; i <= N; i++) begin
            // Explicit wrap so non-power-of-2 N never aliases onto a missing producer.
            idx = int'(last) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!valid && req[idx]) begin
                valid     = 1'b1;
                pick[idx] = 1'b1;
                pick_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin bounded-burst arbiter for the FIFO write port
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int W     = DEF_W,
    parameter int BURST = DEF_BURST
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data_in,
    output logic [N-1:0]   grant,
    input  logic           full,
    output logic           write,
    output logic [W-1:0]   w_data,
    output logic [N-1:0]   accept,
    output logic           busy
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = cnt_width(BURST);

    arb_state_t       state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N-1:0]     pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (req),
        .last     (last_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .valid    (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        write   = 1'b0;
        accept  = '0;
        w_data  = data_in[gidx_q*W +: W];

        case (state_q)
            S_IDLE: begin
                if (pick_valid && !full) begin
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (!req[gidx_q]) begin
                    grant_d = '0;
                    last_d  = gidx_q;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (!full) begin
                    // Reset wins over an in-flight word so nothing lands in the FIFO that cycle.
                    write          = !reset;
                    accept[gidx_q] = !reset;
                    if (cnt_q == CNT_W'(BURST - 1)) begin
                        grant_d = '0;
                        last_d  = gidx_q;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == S_BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - scoreboard bench for fifo_write_arbiter with directed cycle vectors
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] data_in;
    logic [1:0]  grant;
    logic        full;
    logic        write;
    logic [7:0]  w_data;
    logic [1:0]  accept;
    logic        busy;

    fifo_write_arbiter #(.N(2), .W(8), .BURST(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .data_in (data_in),
        .grant   (grant),
        .full    (full),
        .write   (write),
        .w_data  (w_data),
        .accept  (accept),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       id;
        logic [1:0] grant;
        logic       busy;
        logic       write;
        logic [1:0] accept;
        logic [7:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   vid   = 0;

    task automatic vec(input bit r, input bit [1:0] rq, input bit f,
                       input bit [7:0] d0, input bit [7:0] d1,
                       input bit [1:0] g, input bit bz, input bit w,
                       input bit [7:0] wd);
        exp_t e;
        reset   = r;
        req     = rq;
        full    = f;
        data_in = {d1, d0};
        e.id     = vid;
        e.grant  = g;
        e.busy   = bz;
        e.write  = w;
        e.accept = w ? g : 2'b00;
        e.wdata  = wd;
        exp_q.push_back(e);
        vid++;
        @(posedge clk);
        #1;
    endtask

    task automatic vec_n(input int n, input bit [1:0] rq, input bit f,
                         input bit [7:0] d0, input bit [7:0] d1,
                         input bit [1:0] g, input bit bz, input bit w,
                         input bit [7:0] wd);
        for (int k = 0; k < n; k++) begin
            vec(1'b0, rq, f, d0, d1, g, bz, w, wd);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (grant !== e.grant || busy !== e.busy || write !== e.write ||
                    accept !== e.accept || (e.write && w_data !== e.wdata)) begin
                    n_bad++;
                    $display("FAIL v%0d: got grant=%b busy=%b write=%b accept=%b w_data=%h, want grant=%b busy=%b write=%b accept=%b w_data=%h",
                             e.id, grant, busy, write, accept, w_data,
                             e.grant, e.busy, e.write, e.accept, e.wdata);
                end
            end
        end
    end

    initial begin : stimulus
        reset   = 1'b1;
        req     = 2'b11;
        full    = 1'b0;
        data_in = 16'h2211;
        @(posedge clk);
        #1;

        // reset held with both requesting, then producer 0 first
        vec(1'b1, 2'b11, 1'b0, 8'h11, 8'h22, 2'b00, 1'b0, 1'b0, 8'h00);
        vec(1'b1, 2'b11, 1'b0, 8'h11, 8'h22, 2'b00, 1'b0, 1'b0, 8'h00);
        vec(1'b0, 2'b11, 1'b0, 8'h11, 8'h22, 2'b00, 1'b0, 1'b0, 8'h00);

        // burst limit of 4, idle cycle, re-grant, then drop at count 0
        vec_n(4, 2'b01, 1'b0, 8'hA5, 8'h5A, 2'b01, 1'b1, 1'b1, 8'hA5);
        vec_n(1, 2'b01, 1'b0, 8'hA5, 8'h5A, 2'b00, 1'b0, 1'b0, 8'h00);
        vec_n(1, 2'b00, 1'b0, 8'hA5, 8'h5A, 2'b01, 1'b1, 1'b0, 8'h00);
        vec_n(1, 2'b00, 1'b0, 8'hA5, 8'h5A, 2'b00, 1'b0, 1'b0, 8'h00);

        // round robin: last served is 0, so producer 1 wins first
        vec_n(1, 2'b11, 1'b0, 8'h11, 8'h22, 2'b00, 1'b0, 1'b0, 8'h00);
        vec_n(4, 2'b11, 1'b0, 8'h11, 8'h22, 2'b10, 1'b1, 1'b1, 8'h22);
        vec_n(1, 2'b11, 1'b0, 8'h11, 8'h22, 2'b00, 1'b0, 1'b0, 8'h00);
        vec_n(4, 2'b11, 1'b0, 8'h11, 8'h22, 2'b01, 1'b1, 1'b1, 8'h11);
        vec_n(1, 2'b11, 1'b0, 8'h11, 8'h22, 2'b00, 1'b0, 1'b0, 8'h00);
        vec_n(1, 2'b11, 1'b0, 8'h11, 8'h22, 2'b10, 1'b1, 1'b1, 8'h22);

        // early drop of req[1] after one write
        vec_n(1, 2'b01, 1'b0, 8'h11, 8'h22, 2'b10, 1'b1, 1'b0, 8'h00);
        vec_n(1, 2'b01, 1'b0, 8'h11, 8'h22, 2'b00, 1'b0, 1'b0, 8'h00);

        // full stall after two writes, then exactly two more
        vec_n(2, 2'b01, 1'b0, 8'h11, 8'h22, 2'b01, 1'b1, 1'b1, 8'h11);
        vec_n(3, 2'b01, 1'b1, 8'h11, 8'h22, 2'b01, 1'b1, 1'b0, 8'h00);
        vec_n(2, 2'b01, 1'b0, 8'h11, 8'h22, 2'b01, 1'b1, 1'b1, 8'h11);

        // full in IDLE blocks the grant
        vec_n(1, 2'b01, 1'b1, 8'h11, 8'h22, 2'b00, 1'b0, 1'b0, 8'h00);
        vec_n(1, 2'b01, 1'b0, 8'h11, 8'h22, 2'b00, 1'b0, 1'b0, 8'h00);

        // full on the last burst word holds the count
        vec_n(3, 2'b01, 1'b0, 8'h11, 8'h22, 2'b01, 1'b1, 1'b1, 8'h11);
        vec_n(1, 2'b01, 1'b1, 8'h11, 8'h22, 2'b01, 1'b1, 1'b0, 8'h00);
        vec_n(1, 2'b01, 1'b0, 8'h11, 8'h22, 2'b01, 1'b1, 1'b1, 8'h11);

        // reset during the third word of producer 1's burst
        vec_n(1, 2'b11, 1'b0, 8'h11, 8'h22, 2'b00, 1'b0, 1'b0, 8'h00);
        vec_n(2, 2'b11, 1'b0, 8'h11, 8'h22, 2'b10, 1'b1, 1'b1, 8'h22);
        vec(1'b1, 2'b11, 1'b0, 8'h11, 8'h22, 2'b10, 1'b1, 1'b0, 8'h00);
        vec_n(1, 2'b11, 1'b0, 8'h11, 8'h22, 2'b00, 1'b0, 1'b0, 8'h00);
        vec_n(1, 2'b11, 1'b0, 8'h11, 8'h22, 2'b01, 1'b1, 1'b1, 8'h11);
        vec_n(1, 2'b00, 1'b0, 8'h11, 8'h22, 2'b01, 1'b1, 1'b0, 8'h00);
        vec_n(1, 2'b00, 1'b0, 8'h11, 8'h22, 2'b00, 1'b0, 1'b0, 8'h00);

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
